cam_capture_ctrl: RTL and testbench
===================================

# cam_capture_ctrl

Frame-capture sequencer for the camera front end. It tracks camera VSYNC/HREF and gates HREF to the RGB565 byte-pair reader so that only complete, wanted frames reach it. It generates pixel write strobes, coordinates and linear frame-buffer addresses aligned with the reader's RGB outputs, and reports frame completion and line-length errors. It sits between the camera pins, the RGB reader and the frame-buffer write port.

## Interface
- H_SIZE, 640, active pixels per line (2 bytes per pixel)
- V_SIZE, 480, active lines per frame
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_SIZE*V_SIZE

- Cam_pclk  in  1  camera pixel clock; all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Cam_vsync  in  1  camera VSYNC; high = vertical blanking
- Cam_href  in  1  camera HREF; high = active byte on Cam_data
- Start  in  1  one-cycle arm request for a single frame capture
- Continuous  in  1  level; when high, re-arm automatically after every frame
- Buf_ready  in  1  frame buffer can accept a new frame; sampled only at frame start
- Cap_href  out  1  gated HREF to RGB reader = Cam_href AND (state==CAPTURE)
- Pix_we  out  1  one-cycle pixel write strobe, coincident with valid reader RGB
- Pix_addr  out  ADDR_W  linear address of current pixel = Pix_y*H_SIZE + Pix_x
- Pix_x  out  10  column of current pixel
- Pix_y  out  10  row of current pixel
- Busy  out  1  high in every state except IDLE
- Frame_done  out  1  one-cycle pulse when a captured frame ends
- Line_err  out  1  sticky; a line or frame had a wrong pixel count

## Operation
- States: IDLE, ARMED, SYNC, CAPTURE, DONE.
- IDLE: when Start or Continuous is high, go to ARMED. Start in any other state is ignored.
- ARMED: wait for a Cam_vsync rising edge (registered previous value 0, current 1), then go to SYNC. Waiting for this edge guarantees that capture never starts mid-frame.
- SYNC: on a Cam_vsync falling edge:
  - Buf_ready=1: go to CAPTURE, clear Line_err, and clear Pix_x, Pix_y, Pix_addr and the byte phase.
  - Buf_ready=0: drop the frame and return to ARMED.
- CAPTURE:
  - Byte phase toggles on every cycle with Cam_href=1 and is forced to 0 while Cam_href=0.
  - Cycle with Cam_href=1 and phase=1, when Pix_x<H_SIZE: Pix_we<=1 on that edge. On the next Pix_we edge, Pix_x and Pix_addr advance by 1.
  - Same case with Pix_x≥H_SIZE: no Pix_we, and Line_err<=1.
  - HREF falling edge: if pixel count ≠ H_SIZE, Line_err<=1. Pix_x<=0, Pix_y increments, and Pix_addr<=(Pix_y+1)*H_SIZE, computed by accumulation with no multiplier.
  - After V_SIZE completed lines, go to DONE.
  - Cam_vsync rising early (short frame): Line_err<=1, go to DONE.
- DONE: pulse Frame_done for one cycle. Next state is ARMED if Continuous=1, else IDLE.
- Reset (any time, including mid-frame): state IDLE; all outputs 0; phase and counters 0.

## Timing
- Pix_we, Pix_x/Pix_y/Pix_addr are registered. They are valid in the cycle after the Cam_pclk edge that samples the second byte, which is the same cycle the reader's red/green/blue update.
- Cap_href is combinational from Cam_href and the state register; zero added latency.
- Frame_done asserts 1 cycle after the last line's HREF falling edge (or after the early VSYNC edge).
- Minimum frame-to-frame rearm is 1 cycle (DONE→ARMED). The next capture therefore begins at the following VSYNC pulse.
- Simultaneous HREF fall and VSYNC rise in CAPTURE: line bookkeeping is applied first, then the short-frame check.

## Configuration
- CAM_CAPTURE_STATS_EN defined: adds two outputs, both cleared by reset, wrapping at 2^16, and observable one cycle after the event.
  - Frame_cnt [15:0]: incremented in DONE.
  - Drop_cnt [15:0]: incremented when SYNC drops a frame for Buf_ready=0.
- Not defined: both ports and the counters are absent; the rest of the behaviour is identical.

## Test plan
- H_SIZE=4, V_SIZE=3, Start pulse, one clean frame (8 bytes/line, 3 lines):
  - 12 Pix_we pulses, addresses 0..11.
  - Frame_done pulses once, 1 cycle after the third HREF fall.
  - Line_err=0, and the FSM returns to IDLE.
- Start asserted mid-frame (VSYNC low, HREF active): no Pix_we until after the next full VSYNC pulse. The first write is to address 0.
- Buf_ready=0 at the VSYNC fall:
  - No Pix_we and no Frame_done for that frame.
  - Drop_cnt=1 (STATS_EN).
  - With Buf_ready=1 at the next frame, that frame is captured normally.
- Line with 10 bytes (5 pixels) at H_SIZE=4: only 4 Pix_we, Line_err=1. Line_err clears at the next frame's CAPTURE entry.
- Continuous=1, 3 frames, then VSYNC rises after 2 lines: 3 Frame_done pulses, Frame_cnt=3, then a 4th Frame_done with Line_err=1.
- Reset_n pulled low mid-line: all outputs 0 asynchronously, state IDLE. After release, no writes occur without Start or Continuous.

Source files
------------

// File: rtl/cam_capture_ctrl_if.sv
// Camera capture controller bundle: camera pins, arm controls, frame-buffer
// write side and status. The optional statistics counters exist only when
// CAM_CAPTURE_STATS_EN is defined.
interface cam_capture_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic              cam_vsync;
    logic              cam_href;
    logic              start;
    logic              continuous;
    logic              buf_ready;
    logic              cap_href;
    logic              pix_we;
    logic [ADDR_W-1:0] pix_addr;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic              busy;
    logic              frame_done;
    logic              line_err;
`ifdef CAM_CAPTURE_STATS_EN
    logic [15:0]       frame_cnt;
    logic [15:0]       drop_cnt;
`endif

    modport slave (
        input  cam_vsync, cam_href, start, continuous, buf_ready,
        output cap_href, pix_we, pix_addr, pix_x, pix_y, busy, frame_done, line_err
`ifdef CAM_CAPTURE_STATS_EN
        , output frame_cnt, drop_cnt
`endif
    );

    modport master (
        output cam_vsync, cam_href, start, continuous, buf_ready,
        input  cap_href, pix_we, pix_addr, pix_x, pix_y, busy, frame_done, line_err
`ifdef CAM_CAPTURE_STATS_EN
        , input frame_cnt, drop_cnt
`endif
    );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: waits for a full VSYNC pulse, gates HREF to the
// RGB565 byte-pair reader, and produces pixel write strobes, coordinates and
// linear addresses aligned with the reader output.
// Optional feature macro: CAM_CAPTURE_STATS_EN (frame / drop counters).
module cam_capture_ctrl #(
    parameter int H_SIZE = 640,
    parameter int V_SIZE = 480,
    parameter int ADDR_W = 19
) (
    input  logic              i_cam_pclk,
    input  logic              i_reset_n,
    cam_capture_ctrl_if.slave cam_if
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_SYNC    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] H_STEP  = ADDR_W'(H_SIZE);
    localparam logic [9:0]        H_LIM   = 10'(H_SIZE);
    localparam logic [9:0]        V_LAST  = 10'(V_SIZE - 1);
    localparam logic [10:0]       CNT_H   = 11'(H_SIZE);
    localparam logic [10:0]       CNT_MAX = 11'h7FF;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_vsync_prev;
    logic              r_href_prev;
    logic              r_phase;
    logic              r_pix_we;
    logic [9:0]        r_pix_x;
    logic [9:0]        r_pix_y;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [ADDR_W-1:0] r_line_base;
    logic [10:0]       r_pix_cnt;
    logic              r_line_err;
    logic              w_busy;
    logic              w_frame_done;
    logic              w_cap_href;

    // Edge detectors against the registered previous pin values.
    logic w_vs_rise, w_vs_fall, w_href_fall, w_byte2, w_line_last, w_cap_start, w_drop;
    assign w_vs_rise   = cam_if.cam_vsync & ~r_vsync_prev;
    assign w_vs_fall   = ~cam_if.cam_vsync & r_vsync_prev;
    assign w_href_fall = r_href_prev & ~cam_if.cam_href;
    assign w_byte2     = cam_if.cam_href & r_phase;
    assign w_line_last = w_href_fall && (r_pix_y == V_LAST);
    assign w_cap_start = (r_state == S_SYNC) && w_vs_fall && cam_if.buf_ready;
    assign w_drop      = (r_state == S_SYNC) && w_vs_fall && !cam_if.buf_ready;

    // State register.
    always_ff @(posedge i_cam_pclk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    // Next-state logic; a completed last line wins over a coincident early VSYNC.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (cam_if.start || cam_if.continuous) w_state_next = S_ARMED;
            S_ARMED:   if (w_vs_rise) w_state_next = S_SYNC;
            S_SYNC:    if (w_vs_fall) w_state_next = cam_if.buf_ready ? S_CAPTURE : S_ARMED;
            S_CAPTURE: if (w_line_last || w_vs_rise) w_state_next = S_DONE;
            S_DONE:    w_state_next = cam_if.continuous ? S_ARMED : S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs; the HREF gate adds no latency.
    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_frame_done = (r_state == S_DONE);
        w_cap_href   = cam_if.cam_href && (r_state == S_CAPTURE);
    end

    // Pixel datapath: byte phase, strobes, coordinates, address accumulation, error flag.
    always_ff @(posedge i_cam_pclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vsync_prev <= 1'b0;
            r_href_prev  <= 1'b0;
            r_phase      <= 1'b0;
            r_pix_we     <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_addr   <= '0;
            r_line_base  <= '0;
            r_pix_cnt    <= '0;
            r_line_err   <= 1'b0;
        end else begin
            r_vsync_prev <= cam_if.cam_vsync;
            r_href_prev  <= cam_if.cam_href;
            r_pix_we     <= 1'b0;
            if (w_cap_start) begin
                r_phase     <= 1'b0;
                r_pix_x     <= '0;
                r_pix_y     <= '0;
                r_pix_addr  <= '0;
                r_line_base <= '0;
                r_pix_cnt   <= '0;
                r_line_err  <= 1'b0;
            end else if (r_state == S_CAPTURE) begin
                r_phase <= cam_if.cam_href & ~r_phase;
                // The coordinate of a written pixel advances after its strobe.
                if (r_pix_we) begin
                    r_pix_x    <= r_pix_x + 10'd1;
                    r_pix_addr <= r_pix_addr + ADDR_W'(1);
                end
                if (w_byte2) begin
                    if (r_pix_cnt != CNT_MAX) r_pix_cnt <= r_pix_cnt + 11'd1;
                    if (r_pix_x < H_LIM) r_pix_we   <= 1'b1;
                    else                 r_line_err <= 1'b1;
                end
                // Row step: next row base = previous base + H_SIZE.
                if (w_href_fall) begin
                    if (r_pix_cnt != CNT_H) r_line_err <= 1'b1;
                    r_pix_cnt   <= '0;
                    r_pix_x     <= '0;
                    r_pix_y     <= r_pix_y + 10'd1;
                    r_line_base <= r_line_base + H_STEP;
                    r_pix_addr  <= r_line_base + H_STEP;
                end
                if (w_vs_rise && !w_line_last) r_line_err <= 1'b1;
            end
        end
    end

    assign cam_if.cap_href   = w_cap_href;
    assign cam_if.pix_we     = r_pix_we;
    assign cam_if.pix_addr   = r_pix_addr;
    assign cam_if.pix_x      = r_pix_x;
    assign cam_if.pix_y      = r_pix_y;
    assign cam_if.busy       = w_busy;
    assign cam_if.frame_done = w_frame_done;
    assign cam_if.line_err   = r_line_err;

`ifdef CAM_CAPTURE_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_drop_cnt;

    // Count completed captures and frames dropped for lack of a free buffer.
    always_ff @(posedge i_cam_pclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (r_state == S_DONE) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_drop)            r_drop_cnt  <= r_drop_cnt + 16'd1;
        end
    end

    assign cam_if.frame_cnt = r_frame_cnt;
    assign cam_if.drop_cnt  = r_drop_cnt;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Randomized bench for cam_capture_ctrl with a frame-level reference model:
// expected writes and frame-done events are derived from the frame shapes the
// bench drives, then compared against the DUT every cycle.
module tb_cam_capture_ctrl;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cam_capture_ctrl_if #(.ADDR_W(AW)) cam_if ();

    cam_capture_ctrl #(.H_SIZE(H), .V_SIZE(V), .ADDR_W(AW)) dut (
        .i_cam_pclk (clk),
        .i_reset_n  (rst_n),
        .cam_if     (cam_if)
    );

    typedef struct {int cyc; int addr; int x; int y; bit err;} wr_t;
    typedef struct {int cyc; bit err;} dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  checks = 0, errors = 0;
    int  cyc = 0;
    bit  chk_en = 1'b0, exp_gate = 1'b0;
    int  we_seen = 0, done_seen = 0, last_addr = -1;
    bit  m_armed = 1'b0, m_skip = 1'b0, pend_short = 1'b0;
    int  m_frames = 0, m_drops = 0;
    int  lb[V];
    int  len_tab[5] = '{8, 8, 8, 6, 10};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the queued expectations.
    always @(negedge clk) begin : compare
        wr_t w;
        dn_t d;
        bit  want;
        if (chk_en) begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                w = wq.pop_front();
                chk("write_cycle", cyc, w.cyc);
            end
            want = (wq.size() > 0 && wq[0].cyc == cyc);
            chk("pix_we", int'(cam_if.pix_we), int'(want));
            if (want) begin
                w = wq.pop_front();
                if (cam_if.pix_we) begin
                    chk("pix_addr", int'(cam_if.pix_addr), w.addr);
                    chk("pix_x", int'(cam_if.pix_x), w.x);
                    chk("pix_y", int'(cam_if.pix_y), w.y);
                    chk("line_err_at_write", int'(cam_if.line_err), int'(w.err));
                end
            end
            want = (dq.size() > 0 && dq[0].cyc == cyc);
            chk("frame_done", int'(cam_if.frame_done), int'(want));
            if (want) begin
                d = dq.pop_front();
                if (cam_if.frame_done) chk("line_err_at_done", int'(cam_if.line_err), int'(d.err));
            end
            chk("cap_href", int'(cam_if.cap_href), int'(cam_if.cam_href & exp_gate));
        end
        if (cam_if.pix_we) begin
            we_seen++;
            last_addr = int'(cam_if.pix_addr);
            $display("write addr=%0d x=%0d y=%0d err=%0d", cam_if.pix_addr, cam_if.pix_x, cam_if.pix_y, cam_if.line_err);
        end
        if (cam_if.frame_done) begin
            done_seen++;
            $display("frame_done line_err=%0d", cam_if.line_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        cam_if.start = 1'b1;
        step();
        cam_if.start = 1'b0;
        step();
        m_armed = 1'b1;
    endtask

    task automatic set_cont(input bit v);
        cam_if.continuous = v;
        step();
        step();
    endtask

    task automatic set_lines(input int a, input int b, input int c);
        lb[0] = a; lb[1] = b; lb[2] = c;
    endtask

    // Drives one frame: VSYNC pulse, porch, nl lines of lb[] bytes, then tail idle cycles.
    task automatic frame(input int nl, input bit bufr, input bit start_mid, input int tail);
        bit cap, got, err;
        int g;
        if (cam_if.continuous) m_armed = 1'b1;
        cap    = m_armed && !m_skip;
        m_skip = 1'b0;
        got    = cap && bufr;
        cam_if.cam_href  = 1'b0;
        cam_if.cam_vsync = 1'b1;
        if (pend_short) begin
            dq.push_back(dn_t'{cyc + 1, 1'b1});
            pend_short = 1'b0;
        end
        repeat ($urandom_range(3, 5)) step();
        cam_if.buf_ready = bufr;
        cam_if.cam_vsync = 1'b0;
        step();
        repeat ($urandom_range(2, 3)) step();
        if (cap && !bufr) m_drops++;
        exp_gate = got;
        err = 1'b0;
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < lb[l]; b++) begin
                cam_if.cam_href = 1'b1;
                cam_if.start    = start_mid && (l == 0) && (b == 0);
                if (got && (b % 2 == 1) && (b / 2 < H))
                    wq.push_back(wr_t'{cyc + 1, l * H + b / 2, b / 2, l, err});
                step();
                cam_if.start = 1'b0;
            end
            cam_if.cam_href = 1'b0;
            if (lb[l] / 2 != H) err = 1'b1;
            if (got && l == nl - 1 && nl == V) dq.push_back(dn_t'{cyc + 1, err});
            g = (l == nl - 1) ? tail : int'($urandom_range(1, 3));
            repeat (g) step();
        end
        exp_gate = 1'b0;
        if (got) begin
            m_frames++;
            m_armed = cam_if.continuous;
            if (nl < V) begin
                pend_short = 1'b1;
                m_skip     = 1'b1;
            end
        end
        if (start_mid && !got && !m_armed) m_armed = 1'b1;
        $display("frame lines=%0d buf_ready=%0d captured=%0d", nl, bufr, got);
    endtask

    task automatic check_stats();
`ifdef CAM_CAPTURE_STATS_EN
        chk("frame_cnt", int'(cam_if.frame_cnt), m_frames % 65536);
        chk("drop_cnt", int'(cam_if.drop_cnt), m_drops % 65536);
`endif
    endtask

    initial begin : main
        int w0, d0, f0;
        bit sh;
        cam_if.cam_vsync  = 1'b0;
        cam_if.cam_href   = 1'b0;
        cam_if.start      = 1'b0;
        cam_if.continuous = 1'b0;
        cam_if.buf_ready  = 1'b0;
        repeat (3) step();
        chk("reset_pix_we", int'(cam_if.pix_we), 0);
        chk("reset_busy", int'(cam_if.busy), 0);
        chk("reset_line_err", int'(cam_if.line_err), 0);
        chk("reset_pix_addr", int'(cam_if.pix_addr), 0);
        rst_n = 1'b1;
        step();
        chk_en = 1'b1;

        // One clean frame after a Start pulse.
        set_lines(8, 8, 8);
        w0 = we_seen; d0 = done_seen;
        pulse_start();
        frame(V, 1'b1, 1'b0, 4);
        chk("clean_writes", we_seen - w0, 12);
        chk("clean_last_addr", last_addr, 11);
        chk("clean_done", done_seen - d0, 1);
        chk("clean_busy_after", int'(cam_if.busy), 0);
        chk("clean_line_err", int'(cam_if.line_err), 0);

        // Start mid-frame: that frame is skipped, the next is captured from address 0.
        w0 = we_seen;
        frame(V, 1'b1, 1'b1, 4);
        chk("midstart_no_writes", we_seen - w0, 0);
        frame(V, 1'b1, 1'b0, 4);
        chk("midstart_next_writes", we_seen - w0, 12);

        // Buffer not ready: frame dropped, following frame captured.
        w0 = we_seen; d0 = done_seen;
        pulse_start();
        frame(V, 1'b0, 1'b0, 4);
        chk("drop_no_writes", we_seen - w0, 0);
        chk("drop_no_done", done_seen - d0, 0);
`ifdef CAM_CAPTURE_STATS_EN
        chk("drop_cnt_one", int'(cam_if.drop_cnt), 1);
`endif
        frame(V, 1'b1, 1'b0, 4);
        chk("after_drop_writes", we_seen - w0, 12);
        check_stats();

        // Over-long line: 4 writes only, sticky error, cleared at next capture.
        w0 = we_seen;
        set_lines(8, 10, 8);
        pulse_start();
        frame(V, 1'b1, 1'b0, 4);
        chk("long_line_writes", we_seen - w0, 12);
        chk("long_line_err", int'(cam_if.line_err), 1);
        set_lines(8, 8, 8);
        pulse_start();
        frame(V, 1'b1, 1'b0, 4);
        chk("err_cleared", int'(cam_if.line_err), 0);

        // Continuous: three frames, then a short frame.
        d0 = done_seen;
`ifdef CAM_CAPTURE_STATS_EN
        f0 = int'(cam_if.frame_cnt);
`else
        f0 = 0;
`endif
        set_cont(1'b1);
        repeat (3) frame(V, 1'b1, 1'b0, 4);
        chk("cont_done3", done_seen - d0, 3);
`ifdef CAM_CAPTURE_STATS_EN
        chk("cont_frame_cnt3", int'(cam_if.frame_cnt) - f0, 3);
`endif
        frame(2, 1'b1, 1'b0, 1);
        frame(V, 1'b1, 1'b0, 4);
        chk("cont_done4", done_seen - d0, 4);
        chk("short_err_sticky", int'(cam_if.line_err), 1);
        set_cont(1'b0);
        frame(V, 1'b1, 1'b0, 4);
        check_stats();

        // Randomized frames.
        for (int f = 0; f < 14; f++) begin
            if (!pend_short) begin
                if ($urandom_range(0, 3) == 0) set_cont(1'($urandom_range(0, 1)));
                if ($urandom_range(0, 2) == 0) pulse_start();
            end
            for (int l = 0; l < V; l++) lb[l] = len_tab[$urandom_range(0, 4)];
            sh = ($urandom_range(0, 4) == 0) && (f < 13);
            frame(sh ? int'($urandom_range(1, V - 1)) : V,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0,
                  sh ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5)));
            if (!pend_short) check_stats();
        end

        // Reset asserted mid-line.
        repeat (3) step();
        chk_en = 1'b0;
        set_cont(1'b0);
        pulse_start();
        cam_if.cam_vsync = 1'b1;
        repeat (3) step();
        cam_if.buf_ready = 1'b1;
        cam_if.cam_vsync = 1'b0;
        repeat (3) step();
        cam_if.cam_href = 1'b1;
        repeat (4) step();
        chk("pre_reset_pix_we", int'(cam_if.pix_we), 1);
        chk("pre_reset_pix_x", int'(cam_if.pix_x), 1);
        chk("pre_reset_busy", int'(cam_if.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_pix_we", int'(cam_if.pix_we), 0);
        chk("arst_pix_x", int'(cam_if.pix_x), 0);
        chk("arst_pix_y", int'(cam_if.pix_y), 0);
        chk("arst_pix_addr", int'(cam_if.pix_addr), 0);
        chk("arst_busy", int'(cam_if.busy), 0);
        chk("arst_frame_done", int'(cam_if.frame_done), 0);
        chk("arst_line_err", int'(cam_if.line_err), 0);
        chk("arst_cap_href", int'(cam_if.cap_href), 0);
        step();
        cam_if.cam_href = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        wq.delete();
        dq.delete();
        m_armed = 1'b0; m_skip = 1'b0; pend_short = 1'b0;
        m_frames = 0; m_drops = 0;
        chk_en = 1'b1;
        check_stats();
        w0 = we_seen;
        frame(V, 1'b1, 1'b0, 4);
        chk("post_reset_no_writes", we_seen - w0, 0);
        chk("post_reset_idle", int'(cam_if.busy), 0);

        repeat (3) step();
        chk("pending_writes", wq.size(), 0);
        chk("pending_done", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
